// File: rtl/timersoc_rom_arbiter.sv
// Round-robin arbiter for the single-port program memory, shared by the CPU data side (port 0)
// and the debug/boot loader (port 1). It gates loader writes and returns tagged read data.
module timersoc_rom_arbiter #(
  parameter int DEPTH = 20480,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [3:0]    m0_byteenable,
  input  logic [31:0]   m0_writedata,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [3:0]    m1_byteenable,
  input  logic [31:0]   m1_writedata,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,
  input  logic          m1_lock,
  input  logic          load_en,
  input  logic          freeze,
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic [31:0]   mem_writedata,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic          mem_debugaccess,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata,
  output logic [1:0]    err_status,
  input  logic          err_clear
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic          req0, req1, gnt0, gnt1, gnt_any;
  logic [AW-1:0] sel_addr;
  logic          sel_read, oor, illegal_wr, rd_acc, rd_live;
  logic [31:0]   rdata;
  logic          last_grant_q, last_grant_d;
  logic          lock_q, lock_d;
  logic          pend_q, pend_d;
  logic          tag_q, tag_d;
  logic          oor_q, oor_d;
  logic [1:0]    err_q, err_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // last_grant_q=1 means port 1 was served last, so port 0 wins the next contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && !freeze) begin
      if (lock_q) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_any        = gnt0 | gnt1;
  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  always_comb begin
    sel_addr        = gnt1 ? m1_address : m0_address;
    sel_read        = gnt1 ? m1_read : (gnt0 & m0_read);
    oor             = gnt_any & ({1'b0, sel_addr} >= DEPTH_W);
    illegal_wr      = (gnt0 & m0_write) | (gnt1 & m1_write & ~load_en);
    rd_acc          = sel_read;
    mem_address     = gnt_any ? sel_addr : '0;
    mem_byteenable  = gnt1 ? m1_byteenable : (gnt0 ? m0_byteenable : 4'h0);
    mem_writedata   = gnt1 ? m1_writedata : (gnt0 ? m0_writedata : 32'h0);
    mem_chipselect  = gnt_any & ~oor;
    mem_clken       = gnt_any & ~oor;
    mem_write       = gnt1 & m1_write & load_en & ~oor;
    mem_debugaccess = gnt1 & m1_write & load_en & ~oor;
  end

  always_comb begin
    last_grant_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_grant_q);
    lock_d       = !m1_lock ? 1'b0 : (gnt1 ? 1'b1 : lock_q);
    pend_d       = rd_acc;
    tag_d        = rd_acc ? gnt1 : tag_q;
    oor_d        = rd_acc ? oor : oor_q;
    err_d        = err_clear ? 2'b00 : (err_q | {oor, illegal_wr});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      pend_q       <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    oor_q <= oor_d;
  end

  // A return still in flight when reset is applied is suppressed, not delivered.
  assign rd_live          = pend_q & reset_n;
  assign rdata            = oor_q ? 32'h0 : mem_readdata;
  assign m0_readdatavalid = rd_live & ~tag_q;
  assign m1_readdatavalid = rd_live & tag_q;
  assign m0_readdata      = (rd_live & ~tag_q) ? rdata : 32'h0;
  assign m1_readdata      = (rd_live & tag_q) ? rdata : 32'h0;
  assign err_status       = err_q;

endmodule

// File: tb/tb_timersoc_rom_arbiter.sv
// Scoreboard bench for timersoc_rom_arbiter: directed scenarios followed by random traffic,
// with a memory stub and a cycle-level reference model of the arbitration rules.
module tb_timersoc_rom_arbiter;
  localparam int DEPTH = 20480;
  localparam int AW    = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic [31:0]   m0_writedata, m1_writedata, mem_writedata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]   m0_readdata, m1_readdata, mem_readdata;
  logic          m1_lock, load_en, freeze, err_clear;
  logic          mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [1:0]    err_status;

  timersoc_rom_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .m1_lock(m1_lock), .load_en(load_en), .freeze(freeze),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_debugaccess(mem_debugaccess), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_status(err_status), .err_clear(err_clear)
  );

  function automatic logic [31:0] seed_word(int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 5)  return 32'h11111111;
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory stub: one-cycle registered read, byte-lane writes, holds q when not enabled.
  logic [31:0] phys [DEPTH];
  logic [31:0] mem_q;
  bit          init_done;
  assign mem_readdata = mem_q;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) phys[i] <= seed_word(i);
      init_done <= 1'b1;
    end else if (mem_chipselect && mem_clken && int'(mem_address) < DEPTH) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) phys[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_q <= phys[mem_address];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic        tag;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  logic [31:0] refm [DEPTH];
  int total, bad, cyc;
  bit run;
  bit last, locked;
  logic [1:0] err_m;

  logic          s_rn, s_r0, s_w0, s_r1, s_w1, s_lk, s_ld, s_frz, s_clr;
  logic [AW-1:0] s_a0, s_a1;
  logic [3:0]    s_be0, s_be1;
  logic [31:0]   s_wd0, s_wd1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
    end
  endfunction

  task automatic idle();
    s_r0 = 0; s_w0 = 0; s_r1 = 0; s_w1 = 0; s_lk = 0; s_ld = 0; s_frz = 0; s_clr = 0;
    s_rn = 1; s_a0 = '0; s_a1 = '0; s_be0 = 4'hF; s_be1 = 4'hF; s_wd0 = '0; s_wd1 = '0;
  endtask

  // One clock cycle: apply the staged stimulus, compare against the model, advance the model.
  task automatic step();
    int g;
    logic rq0, rq1, oor, ew, rd, wr;
    logic [AW-1:0] a;
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    reset_n = s_rn; m1_lock = s_lk; load_en = s_ld; freeze = s_frz; err_clear = s_clr;
    m0_read = s_r0; m0_write = s_w0; m0_address = s_a0; m0_byteenable = s_be0; m0_writedata = s_wd0;
    m1_read = s_r1; m1_write = s_w1; m1_address = s_a1; m1_byteenable = s_be1; m1_writedata = s_wd1;
    #1;
    rq0 = s_r0 | s_w0;
    rq1 = s_r1 | s_w1;
    g = -1;
    if (s_rn && !s_frz) begin
      if (locked) begin
        if (rq1) g = 1;
      end else if (rq0 && rq1) g = last ? 0 : 1;
      else if (rq0) g = 0;
      else if (rq1) g = 1;
    end
    a   = (g == 1) ? s_a1 : s_a0;
    rd  = (g == 1) ? s_r1 : ((g == 0) ? s_r0 : 1'b0);
    wr  = (g == 1) ? s_w1 : ((g == 0) ? s_w0 : 1'b0);
    oor = (g >= 0) && (int'(a) >= DEPTH);
    ew  = (g == 1) && s_w1 && s_ld && !oor;
    check("m0_waitrequest", m0_waitrequest, rq0 && g != 0);
    check("m1_waitrequest", m1_waitrequest, rq1 && g != 1);
    check("mem_chipselect", mem_chipselect, g >= 0 && !oor);
    check("mem_clken", mem_clken, g >= 0 && !oor);
    check("mem_write", mem_write, ew);
    check("mem_debugaccess", mem_debugaccess, ew);
    check("err_status", err_status, err_m);
    if (g >= 0 && !oor) begin
      check("mem_address", mem_address, a);
      check("mem_byteenable", mem_byteenable, (g == 1) ? s_be1 : s_be0);
      check("mem_writedata", mem_writedata, (g == 1) ? s_wd1 : s_wd0);
    end
    if (ew)
      for (int b = 0; b < 4; b++)
        if (s_be1[b]) refm[a][8*b +: 8] = s_wd1[8*b +: 8];
    if (rd) begin
      e.cyc = cyc + 1;
      e.tag = (g == 1);
      e.data = oor ? 32'h0 : refm[a];
      q.push_back(e);
    end
    if (!s_rn) begin
      while (q.size() > 0 && q[0].cyc == cyc) q.delete(0);
      last = 1; locked = 0; err_m = 2'b00;
    end else begin
      if (g >= 0) last = (g == 1);
      if (!s_lk) locked = 0;
      else if (g == 1) locked = 1;
      if (s_clr) err_m = 2'b00;
      else err_m = err_m | {oor, wr && !(g == 1 && s_ld)};
    end
  endtask

  // Monitor: every presented read return is matched against the oldest expectation.
  always @(negedge clk) begin
    if (run) begin
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (q.size() == 0) begin
          check("rdv_unexpected", {m0_readdatavalid, m1_readdatavalid}, 0);
        end else begin
          mon_e = q.pop_front();
          check("ret_cycle", cyc, mon_e.cyc);
          check("ret_tag", {m0_readdatavalid, m1_readdatavalid}, mon_e.tag ? 2'b01 : 2'b10);
          check("ret_data", mon_e.tag ? m1_readdata : m0_readdata, mon_e.data);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        check("ret_missing", {m0_readdatavalid, m1_readdatavalid}, mon_e.tag ? 2'b01 : 2'b10);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) refm[i] = seed_word(i);
    idle();
    s_rn = 0;
    reset_n = 0; m1_lock = 0; load_en = 0; freeze = 0; err_clear = 0;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    repeat (3) @(posedge clk);
    last = 1; locked = 0; err_m = 2'b00; cyc = 0; run = 1;
    s_r0 = 1; s_r1 = 1;
    step();                                  // held in reset: waitrequest mirrors request

    // contention straight out of reset: 0,1,0,1,0,1
    idle(); s_r0 = 1; s_r1 = 1; s_a0 = 15'd1; s_a1 = 15'd2;
    repeat (6) step();

    // single read of the DEADBEEF word
    idle(); s_r0 = 1; s_a0 = 15'h0010;
    step();
    idle(); step();
    check("single_read_data", m0_readdata, 32'hDEADBEEF);

    // write gating and readback of word 5
    idle(); s_w0 = 1; s_a0 = 15'd5; s_wd0 = 32'h12345678; step();
    idle(); s_w1 = 1; s_a1 = 15'd5; s_wd1 = 32'hCAFEF00D; s_ld = 0; step();
    idle(); s_w1 = 1; s_a1 = 15'd5; s_wd1 = 32'hCAFEF00D; s_ld = 1; s_be1 = 4'h3; step();
    idle(); s_r1 = 1; s_a1 = 15'd5; step();
    idle(); step();
    check("gated_readback", m1_readdata, 32'h1111F00D);

    // out of range, then clear racing a new out-of-range access
    idle(); s_clr = 1; step();
    idle(); s_r1 = 1; s_a1 = 15'd20480; step();
    idle(); step();
    idle(); s_clr = 1; s_r0 = 1; s_a0 = 15'd20481; step();
    idle(); step();

    // lock: m1 holds ownership while m0 waits, then m0 gets in after release
    idle(); s_r1 = 1; s_lk = 1; s_a1 = 15'd3; step();
    idle(); s_r0 = 1; s_r1 = 1; s_lk = 1; s_a0 = 15'd4; s_a1 = 15'd6; repeat (3) step();
    idle(); s_r0 = 1; s_a0 = 15'd4; repeat (2) step();

    // freeze with a read pending
    idle(); s_r0 = 1; s_a0 = 15'h0010; step();
    idle(); s_frz = 1; s_r0 = 1; s_r1 = 1; repeat (3) step();
    idle(); s_r0 = 1; s_r1 = 1; repeat (2) step();

    // reset the cycle after an accepted read
    idle(); s_r0 = 1; s_a0 = 15'd7; step();
    idle(); s_rn = 0; s_r0 = 1; s_r1 = 1; step();
    idle(); s_r0 = 1; s_r1 = 1; s_a0 = 15'd8; s_a1 = 15'd9; repeat (2) step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int op0, op1, p0, p1;
      idle();
      op0 = $urandom_range(0, 3); op1 = $urandom_range(0, 3);
      s_r0 = (op0 == 1 || op0 == 3); s_w0 = (op0 == 2);
      s_r1 = (op1 == 1 || op1 == 3); s_w1 = (op1 == 2);
      p0 = $urandom_range(0, 9); p1 = $urandom_range(0, 9);
      s_a0 = (p0 < 6) ? AW'($urandom_range(0, 15)) : (p0 == 6) ? 15'd20479 :
             (p0 == 7) ? 15'd20480 : (p0 == 8) ? AW'($urandom_range(20481, 32767)) : 15'h0010;
      s_a1 = (p1 < 6) ? AW'($urandom_range(0, 15)) : (p1 == 6) ? 15'd20479 :
             (p1 == 7) ? 15'd20480 : (p1 == 8) ? AW'($urandom_range(20481, 32767)) : 15'h0010;
      s_be0 = 4'($urandom); s_be1 = 4'($urandom);
      s_wd0 = $urandom; s_wd1 = $urandom;
      s_lk  = ($urandom_range(0, 3) == 0);
      s_ld  = $urandom_range(0, 1);
      s_frz = ($urandom_range(0, 9) == 0);
      s_clr = ($urandom_range(0, 7) == 0);
      s_rn  = ($urandom_range(0, 59) != 0);
      step();
    end

    idle(); repeat (3) step();
    run = 0;
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
